// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and digit-count helper for the BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic int bcd_digits(input int w);
    longint unsigned lim, p;
    int d;
    lim = (64'd1 << w) - 64'd1;
    p = 64'd1;
    d = 0;
    while (p <= lim) begin
      p = p * 64'd10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: double-dabble correction, adds 3 to any digit of 5 or more
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);
  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-shift-per-clock double-dabble converter with start/busy/done handshake
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W_BIN    = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W_BIN-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd_out
);
  localparam int BW = 4 * N_DIGITS;
  localparam int SW = BW + W_BIN;
  localparam int CW = $clog2(W_BIN + 1);
  if (N_DIGITS < bcd_digits(W_BIN)) begin : g_too_few_digits
    $error("bin_to_bcd_seq: N_DIGITS too small for W_BIN");
  end
  state_t          state, state_nxt;
  logic [SW-1:0]   sr, sr_nxt, shifted;
  logic [BW-1:0]   adj, bcd_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit   (sr[W_BIN+4*i +: 4]),
      .adjusted(adj[4*i +: 4])
    );
  end
  assign shifted = {adj, sr[W_BIN-1:0]} << 1;
  assign busy    = state == SHIFT;
  assign done    = state == DONE;
  // bcd_out only moves on the final shift so the display never sees partial digits
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    bcd_nxt   = bcd_out;
    if (state == SHIFT) begin
      sr_nxt  = shifted;
      cnt_nxt = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        bcd_nxt   = shifted[SW-1 -: BW];
        state_nxt = DONE;
      end
    end else if (start) begin
      sr_nxt    = {{BW{1'b0}}, bin_in};
      cnt_nxt   = CW'(W_BIN);
      state_nxt = SHIFT;
    end else begin
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      bcd_out <= bcd_nxt;
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized and directed checks of the sequential BCD converter
module tb_bin_to_bcd_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        busy, done;
  logic [19:0] bcd_out;
  int          total = 0;
  int          bad = 0;
  logic [19:0] last_bcd = '0;

  bin_to_bcd_seq dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd_out(bcd_out)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch from idle, wait for done, and check latency, busy span, held output and result.
  task automatic convert(input logic [15:0] v, input string name);
    int lat, busy_n;
    bit held;
    logic [19:0] exp;
    exp = to_bcd(v);
    bin_in = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin_in = 16'($urandom);
    lat = 0;
    busy_n = 0;
    held = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (bcd_out !== last_bcd) held = 1'b0;
      tick();
      lat++;
    end
    total++;
    if (lat !== 16) begin bad++; $display("FAIL %s latency: got %0d want 16", name, lat); end
    total++;
    if (bcd_out !== exp) begin bad++; $display("FAIL %s bcd: got %h want %h", name, bcd_out, exp); end
    total++;
    if (busy_n !== 16) begin bad++; $display("FAIL %s busy cycles: got %0d want 16", name, busy_n); end
    total++;
    if (!held) begin bad++; $display("FAIL %s bcd_out changed before done", name); end
    last_bcd = exp;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s after done: done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if ({busy, done, bcd_out} !== 22'd0) begin
      bad++; $display("FAIL reset_held: busy=%b done=%b bcd=%h want 0 0 0", busy, done, bcd_out);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({busy, done, bcd_out} !== 22'd0) begin
        bad++; $display("FAIL idle_%0d: busy=%b done=%b bcd=%h want 0 0 0", i, busy, done, bcd_out);
      end
    end
  endtask

  task automatic test_directed();
    convert(16'd0, "zero");
    convert(16'hFFFF, "max");
    convert(16'd9999, "n9999");
    convert(16'd1000, "n1000");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) convert(16'($urandom), "random");
  endtask

  task automatic test_ignore_start();
    int dones;
    bin_in = 16'd12345;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin_in = 16'd42;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      tick();
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL ignore_start dones: got %0d want 1", dones); end
    total++;
    if (bcd_out !== 20'h12345) begin bad++; $display("FAIL ignore_start bcd: got %h want 12345", bcd_out); end
    last_bcd = 20'h12345;
  endtask

  task automatic test_back_to_back();
    int lat;
    bin_in = 16'd7;
    start = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    total++;
    if (lat !== 16 || bcd_out !== to_bcd(7)) begin
      bad++; $display("FAIL b2b first: lat=%0d bcd=%h want 16 %h", lat, bcd_out, to_bcd(7));
    end
    bin_in = 16'd250;
    tick();
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b gap: busy=%b done=%b want 1 0", busy, done);
    end
    lat = 1;
    while (!done && lat < 40) begin tick(); lat++; end
    start = 1'b0;
    total++;
    if (lat !== 17 || bcd_out !== to_bcd(250)) begin
      bad++; $display("FAIL b2b second: spacing=%0d bcd=%h want 17 %h", lat, bcd_out, to_bcd(250));
    end
    tick();
    last_bcd = to_bcd(250);
  endtask

  task automatic test_reset_abort();
    bin_in = 16'd54321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    reset = 1'b0;
    #1;
    total++;
    if ({busy, done, bcd_out} !== 22'd0) begin
      bad++; $display("FAIL abort async: busy=%b done=%b bcd=%h want 0 0 0", busy, done, bcd_out);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL abort done: got %b want 0", done); end
    end
    reset = 1'b1;
    last_bcd = '0;
    convert(16'd54321, "restart");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
